// File: rtl/psram_pkg.sv
// psram_pkg: shared state encoding and bus widths for the PSRAM Wishbone arbiter
package psram_pkg;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int DEF_TIMEOUT_CYC = 1024;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} state_t;
endpackage

// File: rtl/psram_wb_arbiter.sv
// psram_wb_arbiter: two-master Wishbone arbiter with registered grant, post-ack idle gap and watchdog
module psram_wb_arbiter
  import psram_pkg::*;
#(
  parameter int FIXED_PRIO  = 0,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = 11
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WB_AW-1:0] m0_adr_i,
  input  logic [WB_DW-1:0] m0_dat_i,
  input  logic [3:0]       m0_sel_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  output logic [WB_DW-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic [WB_AW-1:0] m1_adr_i,
  input  logic [WB_DW-1:0] m1_dat_i,
  input  logic [3:0]       m1_sel_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  output logic [WB_DW-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [WB_AW-1:0] s_adr_o,
  output logic [WB_DW-1:0] s_dat_o,
  output logic [3:0]       s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic [WB_DW-1:0] s_dat_i,
  input  logic             s_ack_i,
  output logic             timeout_o
);
  state_t state, state_nxt;
  logic req0, req1, pick_gnt, gnt, last_grant, hit_ack, hit_tmo, start;
  logic [CNT_W-1:0] wd;
  function automatic logic pick(input logic r0, input logic r1, input logic last);
    return (r0 & r1) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last) : ~r0;
  endfunction
  assign req0     = m0_cyc_i & m0_stb_i;
  assign req1     = m1_cyc_i & m1_stb_i;
  assign pick_gnt = pick(req0, req1, last_grant);
  assign start    = (state == ST_IDLE) & (req0 | req1);
  assign s_cyc_o  = state == ST_REQ;
  assign s_stb_o  = s_cyc_o;
  assign hit_ack  = s_cyc_o & s_ack_i;
  // an ack arriving on the last watchdog cycle still completes normally
  assign hit_tmo  = s_cyc_o & ~s_ack_i & (TIMEOUT_CYC != 0) & (wd == CNT_W'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk_i)
    state <= !rst_n_i ? ST_IDLE : state_nxt;
  always_comb begin
    state_nxt = (state == ST_IDLE) ? (start ? ST_REQ : ST_IDLE) :
                (state == ST_REQ)  ? ((hit_ack | hit_tmo) ? ST_GAP : ST_REQ) : ST_IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s_adr_o    <= '0;
      s_dat_o    <= '0;
      s_sel_o    <= '0;
      s_we_o     <= 1'b0;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      wd         <= '0;
      m0_dat_o   <= '0;
      m1_dat_o   <= '0;
      m0_ack_o   <= 1'b0;
      m1_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m1_err_o   <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      if (start) begin
        gnt        <= pick_gnt;
        last_grant <= pick_gnt;
        s_adr_o    <= pick_gnt ? m1_adr_i : m0_adr_i;
        s_dat_o    <= pick_gnt ? m1_dat_i : m0_dat_i;
        s_sel_o    <= pick_gnt ? m1_sel_i : m0_sel_i;
        s_we_o     <= pick_gnt ? m1_we_i  : m0_we_i;
      end
      wd       <= !s_cyc_o ? '0 : (&wd) ? wd : wd + CNT_W'(1);
      m0_ack_o <= hit_ack & ~gnt;
      m1_ack_o <= hit_ack & gnt;
      m0_err_o <= hit_tmo & ~gnt;
      m1_err_o <= hit_tmo & gnt;
      if (hit_ack & ~s_we_o & ~gnt) m0_dat_o <= s_dat_i;
      if (hit_ack & ~s_we_o & gnt) m1_dat_o <= s_dat_i;
      if (hit_tmo) timeout_o <= 1'b1;
    end
  end
endmodule
